// File: rtl/io_access_arbiter.sv
// io_access_arbiter: shares one memory-mapped IO port between a CPU port (0)
// and a DMA/blitter port (1). Round-robin arbitration with an optional
// ownership lock, a registered issue stage onto the IO bus, and read-response
// tracking across the IO port's fixed read latency.
module io_access_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 32
) (
  input  logic              main_clk,
  input  logic              main_rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [15:0]       req0_wdata,
  input  logic              req0_write,
  input  logic              req0_byte,
  input  logic              req0_lock,
  output logic              rsp0_valid,
  output logic [15:0]       rsp0_data,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [15:0]       req1_wdata,
  input  logic              req1_write,
  input  logic              req1_byte,
  input  logic              req1_lock,
  output logic              rsp1_valid,
  output logic [15:0]       rsp1_data,

  output logic [ADDR_W-1:0] io_address,
  output logic [15:0]       io_data_in,
  output logic [1:0]        io_control,
  input  logic [15:0]       io_data_out
);

  // Arbitration and lock state
  logic last_grant_q;
  logic lock_held_q, lock_held_d;
  logic lock_owner_q, lock_owner_d;

  // Issue stage registers
  logic [ADDR_W-1:0] io_address_q, io_address_d;
  logic [15:0]       io_data_in_q, io_data_in_d;
  logic [1:0]        io_control_q, io_control_d;

  // Read tracking: one entry per cycle of IO read latency; the response
  // registers below form the final entry of the pipeline.
  logic [READ_LATENCY-1:0] trk_vld_q;
  logic [READ_LATENCY-1:0] trk_port_q;

  // Response registers
  logic        rsp0_valid_q, rsp1_valid_q;
  logic [15:0] rsp0_data_q, rsp1_data_q;

  // Grant / accept signals
  logic              grant0, grant1;
  logic              accept;
  logic              sel;
  logic [ADDR_W-1:0] acc_addr;
  logic [15:0]       acc_wdata;
  logic              acc_write, acc_byte, acc_lock;
  logic              oldest_vld, oldest_port;

  // Combinational arbitration: lock owner only, else single requester, else round-robin
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (lock_held_q) begin
      grant0 = req0_valid && !lock_owner_q;
      grant1 = req1_valid &&  lock_owner_q;
    end else if (req0_valid && req1_valid) begin
      grant0 =  last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign sel        = grant1;

  assign acc_addr  = sel ? req1_addr  : req0_addr;
  assign acc_wdata = sel ? req1_wdata : req0_wdata;
  assign acc_write = sel ? req1_write : req0_write;
  assign acc_byte  = sel ? req1_byte  : req0_byte;
  assign acc_lock  = sel ? req1_lock  : req0_lock;

  // Next-state for lock ownership and the IO bus issue registers
  always_comb begin
    lock_held_d  = lock_held_q;
    lock_owner_d = lock_owner_q;
    io_address_d = '0;
    io_control_d = 2'b00;
    io_data_in_d = io_data_in_q;
    if (accept) begin
      io_address_d = acc_addr;
      io_control_d = {acc_write, acc_byte};
      io_data_in_d = acc_wdata;
      if (acc_lock) begin
        lock_held_d  = 1'b1;
        lock_owner_d = sel;
      end else if (lock_held_q && (lock_owner_q == sel)) begin
        lock_held_d  = 1'b0;
      end
    end
  end

  // Arbitration state, issue registers and lock ownership
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      last_grant_q <= 1'b1;
      lock_held_q  <= 1'b0;
      lock_owner_q <= 1'b0;
      io_address_q <= '0;
      io_data_in_q <= '0;
      io_control_q <= 2'b00;
    end else begin
      if (accept) begin
        last_grant_q <= sel;
      end
      lock_held_q  <= lock_held_d;
      lock_owner_q <= lock_owner_d;
      io_address_q <= io_address_d;
      io_data_in_q <= io_data_in_d;
      io_control_q <= io_control_d;
    end
  end

  // Shift issued reads through the latency pipeline, tagged with their port
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      trk_vld_q  <= '0;
      trk_port_q <= '0;
    end else begin
      trk_vld_q[0]  <= accept && !acc_write;
      trk_port_q[0] <= sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        trk_vld_q[i]  <= trk_vld_q[i-1];
        trk_port_q[i] <= trk_port_q[i-1];
      end
    end
  end

  assign oldest_vld  = trk_vld_q[READ_LATENCY-1];
  assign oldest_port = trk_port_q[READ_LATENCY-1];

  // Capture IO read data for the oldest in-flight read; data holds otherwise
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= oldest_vld && !oldest_port;
      rsp1_valid_q <= oldest_vld &&  oldest_port;
      if (oldest_vld && !oldest_port) begin
        rsp0_data_q <= io_data_out;
      end
      if (oldest_vld && oldest_port) begin
        rsp1_data_q <= io_data_out;
      end
    end
  end

  assign io_address = io_address_q;
  assign io_data_in = io_data_in_q;
  assign io_control = io_control_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_io_access_arbiter.sv
// Testbench for io_access_arbiter: directed vector table, hand-written lock and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_io_access_arbiter;

  logic        main_clk = 1'b0;
  logic        main_rst_n = 1'b1;
  logic        req0_valid, req0_write, req0_byte, req0_lock;
  logic [31:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_write, req1_byte, req1_lock;
  logic [31:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_data, rsp1_data;
  logic [31:0] io_address;
  logic [15:0] io_data_in;
  logic [1:0]  io_control;
  logic [15:0] io_data_out;
  logic [31:0] io_dly;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        v, w, b, l;
    logic [31:0] a;
    logic [15:0] d;
  } req_t;

  typedef struct packed {
    req_t        r0, r1;
    logic        er0, er1;
    logic [31:0] eaddr;
    logic [1:0]  ectl;
    logic [15:0] edin;
    logic        ers0, ers1;
    logic [15:0] erd;
  } vec_t;

  typedef struct {
    int          port;
    int          due;
    logic [15:0] data;
  } pend_t;

  io_access_arbiter #(.READ_LATENCY(2), .ADDR_W(32)) dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_write(req0_write), .req0_byte(req0_byte),
    .req0_lock(req0_lock), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_write(req1_write), .req1_byte(req1_byte),
    .req1_lock(req1_lock), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .io_address(io_address), .io_data_in(io_data_in), .io_control(io_control),
    .io_data_out(io_data_out)
  );

  always #5 main_clk = ~main_clk;

  // IO port model: the bus address is registered once more inside the device,
  // and read data is a fixed function of that address.
  function automatic logic [15:0] io_resp(logic [31:0] a);
    return a[31:16] ^ a[15:0] ^ 16'h3EFF;
  endfunction

  always @(posedge main_clk) io_dly <= io_address;
  assign io_data_out = io_resp(io_dly);

  function automatic req_t idle();
    return '0;
  endfunction

  function automatic req_t rd(logic [31:0] a, logic l);
    req_t r;
    r = '0; r.v = 1'b1; r.a = a; r.l = l;
    return r;
  endfunction

  function automatic req_t wr(logic [31:0] a, logic [15:0] d, logic b);
    req_t r;
    r = '0; r.v = 1'b1; r.w = 1'b1; r.b = b; r.a = a; r.d = d;
    return r;
  endfunction

  function automatic vec_t mk(req_t r0, req_t r1, logic er0, logic er1,
                              logic [31:0] eaddr, logic [1:0] ectl, logic [15:0] edin,
                              logic ers0, logic ers1, logic [15:0] erd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.er0 = er0; v.er1 = er1; v.eaddr = eaddr;
    v.ectl = ectl; v.edin = edin; v.ers0 = ers0; v.ers1 = ers1; v.erd = erd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(req_t r0, req_t r1);
    req0_valid = r0.v; req0_write = r0.w; req0_byte = r0.b; req0_lock = r0.l;
    req0_addr = r0.a; req0_wdata = r0.d;
    req1_valid = r1.v; req1_write = r1.w; req1_byte = r1.b; req1_lock = r1.l;
    req1_addr = r1.a; req1_wdata = r1.d;
  endtask

  // Apply inputs at posedge+1, settle to posedge+4 for combinational checks
  task automatic phase_a(req_t r0, req_t r1);
    set_in(r0, r1);
    #3;
  endtask

  // Take the clock edge and settle to posedge+1 for registered checks
  task automatic phase_b();
    @(posedge main_clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(idle(), idle());
    main_rst_n = 1'b0;
    #3;
    phase_b();
    phase_b();
    main_rst_n = 1'b1;
  endtask

  vec_t  vt[$];
  pend_t pq[$];

  initial begin
    set_in(idle(), idle());
    #1;
    main_rst_n = 1'b0;
    #2;
    chk("rst_addr", io_address, 32'h0);
    chk("rst_ctl", 32'(io_control), 32'h0);
    chk("rst_din", 32'(io_data_in), 32'h0);
    chk("rst_rsp0v", 32'(rsp0_valid), 32'h0);
    chk("rst_rsp1v", 32'(rsp1_valid), 32'h0);
    chk("rst_rsp0d", 32'(rsp0_data), 32'h0);
    phase_b();
    phase_b();
    main_rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    vt.push_back(mk(rd(32'h8010_0000, 0), idle(), 1, 0, 32'h8010_0000, 2'b00, 16'h0, 0, 0, 16'h0));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h0, 0, 0, 16'h0));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h0, 1, 0, 16'hBEEF));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h0, 0, 0, 16'h0));
    vt.push_back(mk(rd(32'h8000_0100, 0), rd(32'h8000_0200, 0), 0, 1, 32'h8000_0200, 2'b00, 16'h0, 0, 0, 16'h0));
    vt.push_back(mk(rd(32'h8000_0100, 0), rd(32'h8000_0200, 0), 1, 0, 32'h8000_0100, 2'b00, 16'h0, 0, 0, 16'h0));
    vt.push_back(mk(rd(32'h8000_0100, 0), rd(32'h8000_0200, 0), 0, 1, 32'h8000_0200, 2'b00, 16'h0, 0, 1, 16'hBCFF));
    vt.push_back(mk(rd(32'h8000_0100, 0), rd(32'h8000_0200, 0), 1, 0, 32'h8000_0100, 2'b00, 16'h0, 1, 0, 16'hBFFF));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h0, 0, 1, 16'hBCFF));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h0, 1, 0, 16'hBFFF));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h0, 0, 0, 16'h0));
    vt.push_back(mk(idle(), wr(32'h8020_0005, 16'h1234, 1), 0, 1, 32'h8020_0005, 2'b11, 16'h1234, 0, 0, 16'h0));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h1234, 0, 0, 16'h0));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h1234, 0, 0, 16'h0));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'h1234, 0, 0, 16'h0));
    vt.push_back(mk(wr(32'h8030_0002, 16'hCAFE, 0), idle(), 1, 0, 32'h8030_0002, 2'b10, 16'hCAFE, 0, 0, 16'h0));
    vt.push_back(mk(idle(), idle(), 0, 0, 32'h0, 2'b00, 16'hCAFE, 0, 0, 16'h0));

    foreach (vt[i]) begin
      phase_a(vt[i].r0, vt[i].r1);
      chk($sformatf("v%0d_rdy0", i), 32'(req0_ready), 32'(vt[i].er0));
      chk($sformatf("v%0d_rdy1", i), 32'(req1_ready), 32'(vt[i].er1));
      phase_b();
      chk($sformatf("v%0d_addr", i), io_address, vt[i].eaddr);
      chk($sformatf("v%0d_ctl", i), 32'(io_control), 32'(vt[i].ectl));
      chk($sformatf("v%0d_din", i), 32'(io_data_in), 32'(vt[i].edin));
      chk($sformatf("v%0d_rsp0v", i), 32'(rsp0_valid), 32'(vt[i].ers0));
      chk($sformatf("v%0d_rsp1v", i), 32'(rsp1_valid), 32'(vt[i].ers1));
      if (vt[i].ers0) chk($sformatf("v%0d_rsp0d", i), 32'(rsp0_data), 32'(vt[i].erd));
      if (vt[i].ers1) chk($sformatf("v%0d_rsp1d", i), 32'(rsp1_data), 32'(vt[i].erd));
    end

    // ---------------- reset with a read in flight ----------------
    phase_a(rd(32'h8000_0040, 0), idle());
    chk("inflight_rdy0", 32'(req0_ready), 32'h1);
    phase_b();
    set_in(idle(), idle());
    #2;
    main_rst_n = 1'b0;
    #1;
    chk("arst_addr", io_address, 32'h0);
    chk("arst_ctl", 32'(io_control), 32'h0);
    chk("arst_din", 32'(io_data_in), 32'h0);
    chk("arst_rsp0d", 32'(rsp0_data), 32'h0);
    chk("arst_rsp1d", 32'(rsp1_data), 32'h0);
    phase_b();
    main_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      phase_a(idle(), idle());
      phase_b();
      chk($sformatf("arst_norsp0_%0d", k), 32'(rsp0_valid), 32'h0);
      chk($sformatf("arst_norsp1_%0d", k), 32'(rsp1_valid), 32'h0);
    end

    // ---------------- lock sequence (port 0 wins first contention) ----------------
    phase_a(rd(32'h8000_0010, 1), rd(32'h8000_0020, 0));
    chk("lk0_rdy0", 32'(req0_ready), 32'h1);
    chk("lk0_rdy1", 32'(req1_ready), 32'h0);
    phase_b();
    phase_a(idle(), rd(32'h8000_0020, 0));
    chk("lk1_rdy1", 32'(req1_ready), 32'h0);
    phase_b();
    phase_a(idle(), rd(32'h8000_0020, 0));
    chk("lk2_rdy1", 32'(req1_ready), 32'h0);
    phase_b();
    chk("lk2_rsp0v", 32'(rsp0_valid), 32'h1);
    chk("lk2_rsp0d", 32'(rsp0_data), 32'hBEEF);
    phase_a(rd(32'h8000_0030, 0), rd(32'h8000_0020, 0));
    chk("lk3_rdy0", 32'(req0_ready), 32'h1);
    chk("lk3_rdy1", 32'(req1_ready), 32'h0);
    phase_b();
    phase_a(idle(), rd(32'h8000_0020, 0));
    chk("lk4_rdy1", 32'(req1_ready), 32'h1);
    phase_b();
    phase_a(idle(), idle());
    phase_b();
    chk("lk5_rsp0v", 32'(rsp0_valid), 32'h1);
    chk("lk5_rsp0d", 32'(rsp0_data), 32'hBECF);
    phase_a(idle(), idle());
    phase_b();
    chk("lk6_rsp1v", 32'(rsp1_valid), 32'h1);
    chk("lk6_rsp1d", 32'(rsp1_data), 32'hBEDF);
    chk("lk6_rsp0v", 32'(rsp0_valid), 32'h0);

    // ---------------- randomized traffic vs transaction model ----------------
    begin
      int          m_last, m_owner, g;
      logic [31:0] m_addr;
      logic [1:0]  m_ctl;
      logic [15:0] m_din, m_rd0, m_rd1;
      logic        e0, e1;
      req_t        r0, r1, rg;
      do_reset();
      m_last = 1; m_owner = -1;
      m_addr = '0; m_ctl = '0; m_din = '0; m_rd0 = '0; m_rd1 = '0;
      pq.delete();
      for (int n = 0; n < 400; n++) begin
        r0 = '0; r1 = '0;
        r0.v = ($urandom_range(0, 99) < 60); r1.v = ($urandom_range(0, 99) < 60);
        r0.w = 1'($urandom_range(0, 1)); r1.w = 1'($urandom_range(0, 1));
        r0.b = 1'($urandom_range(0, 1)); r1.b = 1'($urandom_range(0, 1));
        r0.l = ($urandom_range(0, 7) == 0); r1.l = ($urandom_range(0, 7) == 0);
        r0.a = $urandom(); r1.a = $urandom();
        r0.a[31] = ($urandom_range(0, 15) != 0); r1.a[31] = ($urandom_range(0, 15) != 0);
        r0.d = 16'($urandom()); r1.d = 16'($urandom());
        // who the rules say wins this cycle
        if (m_owner >= 0) g = ((m_owner == 0 && r0.v) || (m_owner == 1 && r1.v)) ? m_owner : -1;
        else if (r0.v && r1.v) g = 1 - m_last;
        else if (r0.v) g = 0;
        else if (r1.v) g = 1;
        else g = -1;
        phase_a(r0, r1);
        chk("rnd_rdy0", 32'(req0_ready), 32'(g == 0));
        chk("rnd_rdy1", 32'(req1_ready), 32'(g == 1));
        if (g >= 0) begin
          rg = (g == 1) ? r1 : r0;
          m_addr = rg.a; m_ctl = {rg.w, rg.b}; m_din = rg.d; m_last = g;
          if (rg.l) m_owner = g;
          else if (m_owner == g) m_owner = -1;
          if (!rg.w) pq.push_back('{port: g, due: n + 2, data: io_resp(rg.a)});
        end else begin
          m_addr = '0; m_ctl = '0;
        end
        phase_b();
        e0 = 1'b0; e1 = 1'b0;
        if (pq.size() > 0 && pq[0].due == n) begin
          if (pq[0].port == 0) begin e0 = 1'b1; m_rd0 = pq[0].data; end
          else begin e1 = 1'b1; m_rd1 = pq[0].data; end
          void'(pq.pop_front());
        end
        chk("rnd_addr", io_address, m_addr);
        chk("rnd_ctl", 32'(io_control), 32'(m_ctl));
        chk("rnd_din", 32'(io_data_in), 32'(m_din));
        chk("rnd_rsp0v", 32'(rsp0_valid), 32'(e0));
        chk("rnd_rsp1v", 32'(rsp1_valid), 32'(e1));
        chk("rnd_rsp0d", 32'(rsp0_data), 32'(m_rd0));
        chk("rnd_rsp1d", 32'(rsp1_data), 32'(m_rd1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_access_arbiter.md
Name: io_access_arbiter

Overview:
Shares the single memory-mapped IO port (VGA VRAM, SD card controller, PS2 controller) between two requesters: port 0 (CPU) and port 1 (DMA/blitter). The block registers the granted request onto the IO bus and tracks in-flight reads through the IO port's fixed read latency. It returns read data to the issuing port with a valid strobe. A lock input lets one port hold ownership across multi-access device protocols.

Parameters:
READ_LATENCY, 2, cycles from a request appearing on the IO bus to valid data on io_data_out (the IO port registers address/control twice)
ADDR_W, 32, IO address width

Ports:
main_clk  input  1  system clock; all logic on rising edge
main_rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  port 0 request present
req0_ready  output  1  port 0 request accepted this cycle
req0_addr  input  ADDR_W  port 0 byte address; bit 31 must be 1 for IO
req0_wdata  input  16  port 0 write data
req0_write  input  1  1=write, 0=read
req0_byte  input  1  1=byte access, 0=word access
req0_lock  input  1  hold ownership after the current accept
rsp0_valid  output  1  port 0 read data valid, one-cycle pulse
rsp0_data  output  16  port 0 read data
req1_valid, req1_ready, req1_addr, req1_wdata, req1_write, req1_byte, req1_lock, rsp1_valid, rsp1_data  same as port 0, for port 1
io_address  output  ADDR_W  to IO port address
io_data_in  output  16  to IO port write data
io_control  output  2  to IO port {partial_write (=write), byte_op}
io_data_out  input  16  from IO port read data

Behaviour:
- Reset (async, immediate): io_address=0, io_data_in=0, io_control=0, rsp*_valid=0, rsp*_data=0. Reset clears the read-tracking pipeline and lock owner. last_grant resets to 1, so port 0 wins first. Reads in flight at reset never produce a response.
- Arbitration is combinational each cycle:
  - If a lock is held, only the owner may be granted. The other port's ready=0 even if the owner is idle.
  - Otherwise, if exactly one port is valid, that port is granted.
  - If both ports are valid, grant the port != last_grant (round-robin).
  - reqN_ready = grantN. Accept = valid && ready. At most one accept per cycle.
- Lock:
  - An accept with reqN_lock=1 sets or keeps owner=N.
  - An accept by the owner with lock=0 releases ownership at the end of that cycle.
  - Lock is never released without an accept.
- Issue stage (registered):
  - On accept: io_address<=addr, io_data_in<=wdata, io_control<={write, byte}. last_grant<=N.
  - With no accept: io_address<=0, io_control<=0, io_data_in holds its value. Address bit 31=0 selects no device.
- Read tracking:
  - Shift register of READ_LATENCY+1 entries {valid, port}. Each entry is loaded with {accept && !write, N} at issue.
  - When the oldest entry is valid, pulse rspN_valid for its port and set rspN_data<=io_data_out. Data is captured exactly READ_LATENCY cycles after the request appears on the IO bus.
  - Total latency is READ_LATENCY+1 cycles from accept to the rsp_valid edge.
- Writes produce no response. Back-to-back accepts are allowed every cycle, with any read/write mix and either port.
- There is no response backpressure: requesters must take rsp data in the valid cycle.
- rsp*_data holds its last value when rsp*_valid=0.
- A request whose addr[31]=0 is still issued and tracked. The returned data is whatever the IO port presents (undefined); software must not do this.

Test Plan:
1. Reset then port 0 reads 0x8010_0000 (word) with io_data_out modelled as 2-cycle registered 0xBEEF -> req0_ready=1 in cycle 0; io_address=0x8010_0000 and io_control=2'b00 in cycle 1; rsp0_valid=1, rsp0_data=0xBEEF in cycle 3; rsp1_valid stays 0.
2. Both ports valid continuously with reads -> grants alternate 0,1,0,1. Responses arrive in issue order, one per cycle, each on the correct port.
3. Port 1 writes 0x1234 byte to 0x8020_0005 -> io_control=2'b11, io_data_in=0x1234, io_address=0x8020_0005 one cycle later; no rsp pulse on either port.
4. Port 0 accepts with lock=1 while port 1 is valid -> port 1 ready=0 for the next 3 cycles, including cycles where port 0 is idle. Port 0's accept with lock=0 releases ownership; port 1 is granted on the following cycle.
5. Assert main_rst_n=0 one cycle after a read accept -> outputs zero immediately; after release, no rsp pulse appears, and port 0 wins the next contention.
6. Single-cycle accept, then idle -> io_control returns to 0 and io_address to 0 the cycle after issue.
